alu_sequencer: RTL and testbench
================================

# alu_sequencer

Per-thread execute controller for the small GPU core. It accepts one decoded ALU instruction at a time over a valid/ready handshake and reads operands from a local register file. It drives the combinational `alu` block's opcode and operands, captures `result` and `cmp_flag`, then writes back to the register file or the compare-flag register. It is the driver and consumer side of the `alu` interface.

## Interface
Parameters:
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (from definitions.vh): register and datapath width.
- `NUM_REGS`, default 16: register-file depth; R0 reads as zero.
- `REG_ADDR_W`, default 4: register index width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `instr_valid`  in  1  instruction offered.
- `instr_ready`  out  1  high only in IDLE.
- `instr_opcode`  in  4  one of `` `OP_ADD ``/`` `OP_SUB ``/`` `OP_MUL ``/`` `OP_CMP ``/`` `OP_ADDI ``/`` `OP_SUBI ``.
- `instr_rd`, `instr_rs`, `instr_rt`  in  REG_ADDR_W each  destination and source indices.
- `instr_imm`  in  DATA_WIDTH  immediate for ADDI/SUBI.
- `alu_opcode`  out  4  to `alu.opcode`.
- `alu_operand_a`, `alu_operand_b`  out  DATA_WIDTH each  to `alu`.
- `alu_result`  in  DATA_WIDTH  from `alu`.
- `alu_cmp_flag`  in  1  from `alu`.
- `done_valid`  out  1  one-cycle retire pulse.
- `done_rd`  out  REG_ADDR_W  retired destination index.
- `done_data`  out  DATA_WIDTH  retired result.
- `illegal`  out  1  pulses with `done_valid` for an unrecognised opcode.
- `cmp_flag_q`  out  1  registered compare flag.
- `reg_wr_en`, `reg_wr_addr`, `reg_wr_data`  in  1 / REG_ADDR_W / DATA_WIDTH  host register preload.
- `dbg_rd_addr`  in  REG_ADDR_W  combinational debug read index.
- `dbg_rd_data`  out  DATA_WIDTH  debug read data.

## Operation
- FSM states are IDLE → READ → EXEC → WB → IDLE. Reset state is IDLE.
- IDLE: `instr_ready`=1. When `instr_valid`&&`instr_ready`, latch opcode, rd, rs, rt and imm, then go to READ.
- READ: latch `op_a`=R[rs]. For ADDI/SUBI, latch `op_b`=imm; otherwise `op_b`=R[rt]. Go to EXEC.
- EXEC:
  - Drive `alu_opcode`/`alu_operand_*` from the latched values. These outputs are registered and held stable through EXEC only; outside EXEC they are 0.
  - At the edge, capture `alu_result` into `res_q` and `alu_cmp_flag` into `flag_q`. Go to WB.
- WB:
  - Assert `done_valid`, `done_rd`=rd and `done_data`=`res_q`.
  - At the edge, if the opcode is legal and not CMP and rd≠0, write R[rd]=`res_q`.
  - For CMP, update `cmp_flag_q`=`flag_q` and leave the register file unwritten.
  - Return to IDLE.
- Illegal opcode: follows the same 4-state path. `illegal`=1 in WB, `done_data`=0, with no register or flag write.
- Arithmetic truncates to DATA_WIDTH (wrap-around, MUL keeps the low half). This is inherited from `alu` and must not be re-widened.
- R0: reads return 0 and writes are dropped, from both the instruction path and the host port.
- Host write is honoured only in IDLE and dropped in any other state.
  - If a host write coincides with instruction acceptance, both take effect at that edge, and READ sees the new value.
- `dbg_rd_data`=R[`dbg_rd_addr`] combinationally; R0 reads 0.

## Timing
- Reset (async assert, sync-clean deassert):
  - state IDLE, all registers and R[*] = 0.
  - `done_valid`, `illegal` and `cmp_flag_q` = 0.
  - ALU outputs = 0.
  - `instr_ready`=1 in the first cycle after release.
- Latency, with acceptance at edge E0:
  - READ spans E0–E1, EXEC spans E1–E2, WB spans E2–E3.
  - `done_valid` is high for exactly the cycle between E2 and E3.
  - The write is visible on `dbg_rd_data` after E3.
- Throughput is one instruction per 4 cycles. `instr_ready` rises again after E3, so back-to-back acceptance is possible at E4.
- Holding `instr_valid` high while busy must not cause a duplicate accept.
- Reset mid-operation aborts the instruction: no writeback and no `done_valid`.

## Test plan
- Preload R1=5, R2=3, then ADD rd=3 rs=1 rt=2 → `done_valid` 3 cycles after accept with `done_rd`=3, `done_data`=8; R3=8.
- With DATA_WIDTH=8, R1=3, R2=5, SUB rd=4 rs=1 rt=2 → R4=0xFE; MUL of R5=0x10 by R5=0x10 → R6=0x00.
- ADDI rd=7 rs=1 imm=0x10 with R1=0xF8 → R7=0x08, confirming `alu_operand_b`=0x10 during EXEC.
- CMP rs=1(3) rt=2(5) → `cmp_flag_q`=1 after WB and all registers unchanged; CMP rs=2 rt=1 → `cmp_flag_q`=0.
- ADD rd=0 → R0 still reads 0. Opcode outside the defined set → `illegal`=1 together with `done_valid`, `done_data`=0, no state change. A host write while busy is dropped.
- Assert `reset` during EXEC with `instr_valid` held high → no `done_valid`, all R[*]=0, `instr_ready`=1 after release. The next instruction is accepted exactly once.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: per-thread execute controller. Accepts one decoded ALU
// instruction at a time, reads operands from a local register file, drives
// the combinational alu block, then retires the result to the register file
// or the compare-flag register. Fixed four-state path IDLE->READ->EXEC->WB.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef OP_ADD
`define OP_ADD  4'h0
`define OP_SUB  4'h1
`define OP_MUL  4'h2
`define OP_CMP  4'h3
`define OP_ADDI 4'h4
`define OP_SUBI 4'h5
`endif

module alu_sequencer #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int NUM_REGS   = 16,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  // Handshake: an instruction transfers on a rising edge where instr_valid
  // and instr_ready are both high. instr_ready depends only on state (high
  // in IDLE), never on instr_valid; the offered fields need only be stable
  // in the cycle of the transfer.
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [3:0]            instr_opcode,
  input  logic [REG_ADDR_W-1:0] instr_rd,
  input  logic [REG_ADDR_W-1:0] instr_rs,
  input  logic [REG_ADDR_W-1:0] instr_rt,
  input  logic [DATA_WIDTH-1:0] instr_imm,
  output logic [3:0]            alu_opcode,
  output logic [DATA_WIDTH-1:0] alu_operand_a,
  output logic [DATA_WIDTH-1:0] alu_operand_b,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_cmp_flag,
  output logic                  done_valid,
  output logic [REG_ADDR_W-1:0] done_rd,
  output logic [DATA_WIDTH-1:0] done_data,
  output logic                  illegal,
  output logic                  cmp_flag_q,
  input  logic                  reg_wr_en,
  input  logic [REG_ADDR_W-1:0] reg_wr_addr,
  input  logic [DATA_WIDTH-1:0] reg_wr_data,
  input  logic [REG_ADDR_W-1:0] dbg_rd_addr,
  output logic [DATA_WIDTH-1:0] dbg_rd_data,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_op;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [REG_ADDR_W-1:0] r_rs;
  logic [REG_ADDR_W-1:0] r_rt;
  logic [DATA_WIDTH-1:0] r_imm;
  logic [DATA_WIDTH-1:0] r_res;
  logic                  r_flag;
  logic                  r_cmp_flag;
  logic [3:0]            r_alu_opcode;
  logic [DATA_WIDTH-1:0] r_alu_a;
  logic [DATA_WIDTH-1:0] r_alu_b;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic                  w_accept;
  logic                  w_legal;
  logic                  w_is_imm;
  logic                  w_is_cmp;
  logic                  w_wb_write;
  logic [DATA_WIDTH-1:0] w_rs_data;
  logic [DATA_WIDTH-1:0] w_rt_data;

  assign w_accept    = instr_valid && (r_state == S_IDLE);
  assign instr_ready = (r_state == S_IDLE);
  assign dbg_state   = r_state;

  // Decode the latched opcode: legality, immediate form, compare form.
  always_comb begin
    w_legal  = 1'b0;
    w_is_imm = 1'b0;
    w_is_cmp = 1'b0;
    case (r_op)
      `OP_ADD, `OP_SUB, `OP_MUL: w_legal = 1'b1;
      `OP_CMP: begin
        w_legal  = 1'b1;
        w_is_cmp = 1'b1;
      end
      `OP_ADDI, `OP_SUBI: begin
        w_legal  = 1'b1;
        w_is_imm = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // R0 is hardwired to zero on every read port.
  assign w_rs_data   = (r_rs == '0) ? '0 : r_regs[r_rs];
  assign w_rt_data   = (r_rt == '0) ? '0 : r_regs[r_rt];
  assign dbg_rd_data = (dbg_rd_addr == '0) ? '0 : r_regs[dbg_rd_addr];
  assign w_wb_write  = (r_state == S_WB) && w_legal && !w_is_cmp && (r_rd != '0);

  // Next-state logic: one fixed pass through READ, EXEC and WB per accept.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (instr_valid) w_next = S_READ;
      S_READ:  w_next = S_EXEC;
      S_EXEC:  w_next = S_WB;
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Latch the instruction fields on handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op  <= '0;
      r_rd  <= '0;
      r_rs  <= '0;
      r_rt  <= '0;
      r_imm <= '0;
    end else if (w_accept) begin
      r_op  <= instr_opcode;
      r_rd  <= instr_rd;
      r_rs  <= instr_rs;
      r_rt  <= instr_rt;
      r_imm <= instr_imm;
    end
  end

  // Operand fetch in READ loads the alu drive registers, so they hold the
  // operands for the whole of EXEC and return to zero everywhere else.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alu_opcode <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
    end else if (r_state == S_READ) begin
      r_alu_opcode <= r_op;
      r_alu_a      <= w_rs_data;
      r_alu_b      <= w_is_imm ? r_imm : w_rt_data;
    end else begin
      r_alu_opcode <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
    end
  end

  assign alu_opcode    = r_alu_opcode;
  assign alu_operand_a = r_alu_a;
  assign alu_operand_b = r_alu_b;

  // Capture the alu outputs at the end of EXEC; the width is the alu's own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_res  <= '0;
      r_flag <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_res  <= alu_result;
      r_flag <= alu_cmp_flag;
    end
  end

  // Compare flag retires only for a legal CMP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cmp_flag <= 1'b0;
    else if ((r_state == S_WB) && w_legal && w_is_cmp) r_cmp_flag <= r_flag;
  end

  assign cmp_flag_q = r_cmp_flag;

  // Register file: host preload only in IDLE, writeback only in WB; the two
  // are never active together and writes to R0 are discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if ((r_state == S_IDLE) && reg_wr_en && (reg_wr_addr != '0)) begin
      r_regs[reg_wr_addr] <= reg_wr_data;
    end else if (w_wb_write) begin
      r_regs[r_rd] <= r_res;
    end
  end

  assign done_valid = (r_state == S_WB);
  assign done_rd    = r_rd;
  assign done_data  = w_legal ? r_res : '0;
  assign illegal    = (r_state == S_WB) && !w_legal;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: behavioural alu model on the alu port,
// reference register file, and a retire scoreboard fed at issue time.
`timescale 1ns/1ps

module tb_alu_sequencer;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NR = 16;
  localparam int W  = 1 + AW + DW;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_CMP  = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_SUBI = 4'h5;
  localparam logic [3:0] OP_BAD  = 4'hF;

  logic          clk;
  logic          reset;
  logic          instr_valid;
  logic          instr_ready;
  logic [3:0]    instr_opcode;
  logic [AW-1:0] instr_rd, instr_rs, instr_rt;
  logic [DW-1:0] instr_imm;
  logic [3:0]    alu_opcode;
  logic [DW-1:0] alu_operand_a, alu_operand_b, alu_result;
  logic          alu_cmp_flag;
  logic          done_valid;
  logic [AW-1:0] done_rd;
  logic [DW-1:0] done_data;
  logic          illegal;
  logic          cmp_flag_q;
  logic          reg_wr_en;
  logic [AW-1:0] reg_wr_addr;
  logic [DW-1:0] reg_wr_data;
  logic [AW-1:0] dbg_rd_addr;
  logic [DW-1:0] dbg_rd_data;
  logic [1:0]    dbg_state;

  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] ref_regs [NR];
  logic          ref_flag;
  int            n_vec;
  int            n_err;
  logic [2*DW-1:0] w_prod;

  alu_sequencer #(.DATA_WIDTH(DW), .NUM_REGS(NR), .REG_ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_rd(instr_rd), .instr_rs(instr_rs),
    .instr_rt(instr_rt), .instr_imm(instr_imm),
    .alu_opcode(alu_opcode), .alu_operand_a(alu_operand_a),
    .alu_operand_b(alu_operand_b), .alu_result(alu_result),
    .alu_cmp_flag(alu_cmp_flag),
    .done_valid(done_valid), .done_rd(done_rd), .done_data(done_data),
    .illegal(illegal), .cmp_flag_q(cmp_flag_q),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .dbg_rd_addr(dbg_rd_addr), .dbg_rd_data(dbg_rd_data), .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural alu: unknown opcodes return a marker value so a leak shows.
  assign w_prod = alu_operand_a * alu_operand_b;
  always_comb begin
    alu_result   = 8'hA5;
    alu_cmp_flag = (alu_operand_a < alu_operand_b);
    case (alu_opcode)
      OP_ADD, OP_ADDI:         alu_result = alu_operand_a + alu_operand_b;
      OP_SUB, OP_SUBI, OP_CMP: alu_result = alu_operand_a - alu_operand_b;
      OP_MUL:                  alu_result = w_prod[DW-1:0];
      default:                 alu_result = 8'hA5;
    endcase
  end

  // Scoreboard: every retire pulse pops one expectation.
  always @(negedge clk) begin
    if (!reset && done_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL retire_unexpected: got rd=%0d data=%h illegal=%b, required none", done_rd, done_data, illegal);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({illegal, done_rd, done_data} !== e) begin
          n_err++;
          $display("FAIL retire: got ill=%b rd=%0d data=%h, required ill=%b rd=%0d data=%h",
                   illegal, done_rd, done_data, e[W-1], e[DW+AW-1:DW], e[DW-1:0]);
        end
      end
    end
    if (!reset && illegal && !done_valid) begin
      n_err++;
      $display("FAIL illegal_alone: got illegal=1 done_valid=0, required illegal only with done_valid");
    end
  end

  // Driver tasks
  task automatic model_push(input logic [3:0] op, input logic [AW-1:0] rd, rs, rt,
                            input logic [DW-1:0] imm);
    logic [DW-1:0] a, b, res;
    logic [2*DW-1:0] p;
    logic legal, flag;
    a = (rs == 0) ? '0 : ref_regs[rs];
    b = (op == OP_ADDI || op == OP_SUBI) ? imm : ((rt == 0) ? '0 : ref_regs[rt]);
    legal = (op <= OP_SUBI);
    p = a * b;
    flag = (a < b);
    case (op)
      OP_ADD, OP_ADDI:         res = a + b;
      OP_SUB, OP_SUBI, OP_CMP: res = a - b;
      OP_MUL:                  res = p[DW-1:0];
      default:                 res = '0;
    endcase
    exp_q.push_back({!legal, rd, legal ? res : {DW{1'b0}}});
    if (legal && op != OP_CMP && rd != 0) ref_regs[rd] = res;
    if (legal && op == OP_CMP) ref_flag = flag;
  endtask

  task automatic drive_instr(input logic [3:0] op, input logic [AW-1:0] rd, rs, rt,
                             input logic [DW-1:0] imm);
    instr_opcode = op;
    instr_rd = rd;
    instr_rs = rs;
    instr_rt = rt;
    instr_imm = imm;
    instr_valid = 1'b1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!instr_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!instr_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: got instr_ready=0, required 1 within 20 cycles");
    end
  endtask

  task automatic host_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    reg_wr_en = 1'b1;
    reg_wr_addr = addr;
    reg_wr_data = data;
    @(posedge clk);
    #1 reg_wr_en = 1'b0;
    if (addr != 0) ref_regs[addr] = data;
    @(negedge clk);
  endtask

  // Issues one instruction from a negedge, returns retire latency in cycles
  // after the accept edge and the alu operand B seen during EXEC; ends on the
  // negedge after the writeback edge.
  task automatic run_instr(input logic [3:0] op, input logic [AW-1:0] rd, rs, rt,
                           input logic [DW-1:0] imm, output int lat,
                           output logic [DW-1:0] exec_b);
    wait_ready();
    drive_instr(op, rd, rs, rt, imm);
    model_push(op, rd, rs, rt, imm);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    lat = 0;
    exec_b = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 2) exec_b = alu_operand_b;
      if (done_valid) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no done_valid, required within 8 cycles");
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Tests
  task automatic test_reset();
    reset = 1'b1;
    instr_valid = 1'b0;
    instr_opcode = '0; instr_rd = '0; instr_rs = '0; instr_rt = '0; instr_imm = '0;
    reg_wr_en = 1'b0; reg_wr_addr = '0; reg_wr_data = '0; dbg_rd_addr = '0;
    for (int i = 0; i < NR; i++) ref_regs[i] = '0;
    ref_flag = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    n_vec++;
    if ({instr_ready, done_valid, illegal, cmp_flag_q} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_ctrl: got rdy/done/ill/flag=%b, required 1000",
               {instr_ready, done_valid, illegal, cmp_flag_q});
    end
    n_vec++;
    if ({alu_opcode, alu_operand_a, alu_operand_b} !== '0) begin
      n_err++;
      $display("FAIL reset_alu: got op=%h a=%h b=%h, required 0", alu_opcode, alu_operand_a, alu_operand_b);
    end
    for (int i = 0; i < NR; i++) begin
      dbg_rd_addr = i[AW-1:0];
      #1;
      n_vec++;
      if (dbg_rd_data !== 8'h00) begin
        n_err++;
        $display("FAIL reset_reg: got R%0d=%h, required 00", i, dbg_rd_data);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_add();
    int lat;
    logic [DW-1:0] eb;
    host_write(1, 8'd5);
    host_write(2, 8'd3);
    run_instr(OP_ADD, 3, 1, 2, 8'h00, lat, eb);
    n_vec++;
    if (lat !== 3) begin
      n_err++;
      $display("FAIL add_latency: got %0d, required 3", lat);
    end
    dbg_rd_addr = 3; #1;
    n_vec++;
    if (dbg_rd_data !== 8'd8) begin
      n_err++;
      $display("FAIL add_r3: got %h, required 08", dbg_rd_data);
    end
  endtask

  task automatic test_sub_mul();
    int lat;
    logic [DW-1:0] eb;
    host_write(1, 8'd3);
    host_write(2, 8'd5);
    run_instr(OP_SUB, 4, 1, 2, 8'h00, lat, eb);
    host_write(5, 8'h10);
    run_instr(OP_MUL, 6, 5, 5, 8'h00, lat, eb);
    dbg_rd_addr = 4; #1;
    n_vec++;
    if (dbg_rd_data !== 8'hFE) begin
      n_err++;
      $display("FAIL sub_r4: got %h, required fe", dbg_rd_data);
    end
    dbg_rd_addr = 6; #1;
    n_vec++;
    if (dbg_rd_data !== 8'h00) begin
      n_err++;
      $display("FAIL mul_r6: got %h, required 00", dbg_rd_data);
    end
  endtask

  task automatic test_addi();
    int lat;
    logic [DW-1:0] eb;
    host_write(1, 8'hF8);
    run_instr(OP_ADDI, 7, 1, 9, 8'h10, lat, eb);
    n_vec++;
    if (eb !== 8'h10) begin
      n_err++;
      $display("FAIL addi_opb: got %h, required 10", eb);
    end
    dbg_rd_addr = 7; #1;
    n_vec++;
    if (dbg_rd_data !== 8'h08) begin
      n_err++;
      $display("FAIL addi_r7: got %h, required 08", dbg_rd_data);
    end
    run_instr(OP_SUBI, 8, 1, 0, 8'hF9, lat, eb);
    dbg_rd_addr = 8; #1;
    n_vec++;
    if (dbg_rd_data !== 8'hFF) begin
      n_err++;
      $display("FAIL subi_r8: got %h, required ff", dbg_rd_data);
    end
  endtask

  task automatic test_cmp();
    int lat;
    logic [DW-1:0] eb;
    host_write(1, 8'd3);
    host_write(2, 8'd5);
    host_write(9, 8'h33);
    run_instr(OP_CMP, 9, 1, 2, 8'h00, lat, eb);
    n_vec++;
    if (cmp_flag_q !== 1'b1) begin
      n_err++;
      $display("FAIL cmp_lt: got %b, required 1", cmp_flag_q);
    end
    for (int i = 0; i < NR; i++) begin
      dbg_rd_addr = i[AW-1:0];
      #1;
      n_vec++;
      if (dbg_rd_data !== ref_regs[i]) begin
        n_err++;
        $display("FAIL cmp_regs: got R%0d=%h, required %h", i, dbg_rd_data, ref_regs[i]);
      end
    end
    run_instr(OP_CMP, 9, 2, 1, 8'h00, lat, eb);
    n_vec++;
    if (cmp_flag_q !== 1'b0) begin
      n_err++;
      $display("FAIL cmp_ge: got %b, required 0", cmp_flag_q);
    end
  endtask

  task automatic test_r0_illegal();
    int lat;
    logic [DW-1:0] eb;
    run_instr(OP_ADD, 0, 1, 2, 8'h00, lat, eb);
    host_write(0, 8'h55);
    dbg_rd_addr = 0; #1;
    n_vec++;
    if (dbg_rd_data !== 8'h00) begin
      n_err++;
      $display("FAIL r0_zero: got %h, required 00", dbg_rd_data);
    end
    host_write(10, 8'h6C);
    host_write(2, 8'd5);
    run_instr(OP_CMP, 11, 1, 2, 8'h00, lat, eb);
    run_instr(OP_BAD, 10, 1, 2, 8'h00, lat, eb);
    dbg_rd_addr = 10; #1;
    n_vec++;
    if (dbg_rd_data !== 8'h6C) begin
      n_err++;
      $display("FAIL illegal_nowrite: got R10=%h, required 6c", dbg_rd_data);
    end
    n_vec++;
    if (cmp_flag_q !== 1'b1) begin
      n_err++;
      $display("FAIL illegal_flag: got %b, required 1", cmp_flag_q);
    end
  endtask

  task automatic test_host_busy();
    int got;
    host_write(9, 8'h33);
    wait_ready();
    drive_instr(OP_ADD, 3, 1, 2, 8'h00);
    model_push(OP_ADD, 3, 1, 2, 8'h00);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    reg_wr_en = 1'b1; reg_wr_addr = 9; reg_wr_data = 8'h77;
    got = 0;
    for (int k = 1; k <= 8 && got == 0; k++) begin
      @(negedge clk);
      if (done_valid) got = k;
    end
    @(posedge clk);
    @(negedge clk);
    reg_wr_en = 1'b0;
    dbg_rd_addr = 9; #1;
    n_vec++;
    if (dbg_rd_data !== 8'h33) begin
      n_err++;
      $display("FAIL host_busy: got R9=%h, required 33", dbg_rd_data);
    end
    // Host write on the same edge as acceptance is seen by the operand fetch.
    drive_instr(OP_ADD, 11, 1, 1, 8'h00);
    reg_wr_en = 1'b1; reg_wr_addr = 1; reg_wr_data = 8'h20;
    ref_regs[1] = 8'h20;
    model_push(OP_ADD, 11, 1, 1, 8'h00);
    @(posedge clk);
    #1 instr_valid = 1'b0; reg_wr_en = 1'b0;
    repeat (4) @(negedge clk);
    dbg_rd_addr = 11; #1;
    n_vec++;
    if (dbg_rd_data !== 8'h40) begin
      n_err++;
      $display("FAIL host_coincide: got R11=%h, required 40", dbg_rd_data);
    end
  endtask

  task automatic test_back_to_back();
    int k0, gap;
    host_write(1, 8'h11);
    host_write(2, 8'h22);
    wait_ready();
    drive_instr(OP_ADD, 12, 1, 2, 8'h00);
    model_push(OP_ADD, 12, 1, 2, 8'h00);
    @(posedge clk);
    k0 = 0;
    for (int k = 1; k <= 8 && k0 == 0; k++) begin
      @(negedge clk);
      if (done_valid) k0 = k;
    end
    drive_instr(OP_ADD, 13, 12, 12, 8'h00);
    model_push(OP_ADD, 13, 12, 12, 8'h00);
    gap = 0;
    for (int k = 1; k <= 10 && gap == 0; k++) begin
      @(negedge clk);
      if (k == 2) instr_valid = 1'b0;
      if (done_valid) gap = k;
    end
    n_vec++;
    if (gap !== 4) begin
      n_err++;
      $display("FAIL b2b_gap: got %0d cycles between retires, required 4", gap);
    end
    @(posedge clk);
    @(negedge clk);
    dbg_rd_addr = 13; #1;
    n_vec++;
    if (dbg_rd_data !== 8'h66) begin
      n_err++;
      $display("FAIL b2b_r13: got %h, required 66", dbg_rd_data);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    host_write(1, 8'd3);
    wait_ready();
    drive_instr(OP_ADDI, 14, 1, 0, 8'h2A);
    model_push(OP_ADDI, 14, 1, 0, 8'h2A);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (alu_opcode !== OP_ADDI || alu_operand_a !== 8'd3) begin
      n_err++;
      $display("FAIL exec_drive: got op=%h a=%h, required 4 03", alu_opcode, alu_operand_a);
    end
    reset = 1'b1;
    exp_q.delete();
    for (int i = 0; i < NR; i++) ref_regs[i] = '0;
    ref_flag = 1'b0;
    #1;
    n_vec++;
    if ({done_valid, alu_opcode, alu_operand_a, alu_operand_b} !== '0) begin
      n_err++;
      $display("FAIL reset_abort: got done=%b op=%h a=%h b=%h, required 0",
               done_valid, alu_opcode, alu_operand_a, alu_operand_b);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    n_vec++;
    if (instr_ready !== 1'b1 || cmp_flag_q !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got ready=%b flag=%b, required 1 0", instr_ready, cmp_flag_q);
    end
    for (int i = 0; i < NR; i++) begin
      dbg_rd_addr = i[AW-1:0];
      #1;
      n_vec++;
      if (dbg_rd_data !== 8'h00) begin
        n_err++;
        $display("FAIL reset_mid_reg: got R%0d=%h, required 00", i, dbg_rd_data);
      end
    end
    model_push(OP_ADDI, 14, 1, 0, 8'h2A);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done_valid) pulses++;
    end
    n_vec++;
    if (pulses !== 1) begin
      n_err++;
      $display("FAIL reset_reaccept: got %0d retires, required 1", pulses);
    end
    dbg_rd_addr = 14; #1;
    n_vec++;
    if (dbg_rd_data !== 8'h2A) begin
      n_err++;
      $display("FAIL reset_r14: got %h, required 2a", dbg_rd_data);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [DW-1:0] eb;
    for (int n = 0; n < 12; n++) begin
      host_write(AW'($urandom_range(1, NR - 1)), DW'($urandom_range(0, 255)));
      run_instr(4'($urandom_range(0, 5)), AW'($urandom_range(0, NR - 1)),
                AW'($urandom_range(0, NR - 1)), AW'($urandom_range(0, NR - 1)),
                DW'($urandom_range(0, 255)), lat, eb);
    end
    for (int i = 0; i < NR; i++) begin
      dbg_rd_addr = i[AW-1:0];
      #1;
      n_vec++;
      if (dbg_rd_data !== ref_regs[i]) begin
        n_err++;
        $display("FAIL random_regs: got R%0d=%h, required %h", i, dbg_rd_data, ref_regs[i]);
      end
    end
    n_vec++;
    if (cmp_flag_q !== ref_flag) begin
      n_err++;
      $display("FAIL random_flag: got %b, required %b", cmp_flag_q, ref_flag);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_add();
    test_sub_mul();
    test_addi();
    test_cmp();
    test_r0_illegal();
    test_host_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_retire: got %0d outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
